snapshot_capture_ctrl: RTL and testbench
========================================

# snapshot_capture_ctrl

Write-side sequencer for a snapshot capture buffer. It drives port A of the 128-bit × 4096-word snapshot BRAM, and software reads the buffer back over port B. The block arms on a software control edge, waits for a trigger, then writes qualified samples into the BRAM one word per valid cycle, either once (one-shot) or continuously with wrap-around. It reports completion and the fill pointer to the software status register.

## Interface
Parameters:
- DATA_WIDTH, 128, sample and BRAM word width
- ADDR_WIDTH, 12, BRAM port A address width; depth = 2**ADDR_WIDTH

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- arm  in  1  level from software control register; rising edge arms
- trig  in  1  level-sensitive capture trigger
- force_trig  in  1  sampled with the arm edge; 1 = start capture without waiting for trig
- circ  in  1  sampled with the arm edge; 1 = circular mode (only with SNAP_CIRC_EN)
- stop  in  1  ends circular capture (only with SNAP_CIRC_EN)
- din_valid  in  1  sample qualifier
- din  in  DATA_WIDTH  sample data
- bram_we  out  1  port A write enable
- bram_en_a  out  1  port A enable; always equal to bram_we
- bram_addr  out  ADDR_WIDTH  port A address
- bram_wr_data  out  DATA_WIDTH  port A write data
- status_busy  out  1  high in ARMED or CAPTURE
- status_done  out  1  high in DONE
- status_addr  out  ADDR_WIDTH+1  {wrapped, next write pointer}

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- Arm edge detection uses register arm_q; edge = arm & ~arm_q.
- Arm edge in any state:
  - goes to ARMED, or directly to CAPTURE if force_trig = 1
  - clears the pointer and the wrapped flag
  - latches circ into mode_circ
  - an in-progress capture is aborted
- ARMED: trig = 1 goes to CAPTURE. A din_valid on the trigger cycle is captured as word 0.
- CAPTURE: each din_valid writes din at address ptr, then ptr increments modulo 2**ADDR_WIDTH.
- One-shot (mode_circ = 0):
  - the write at ptr = 2**ADDR_WIDTH−1 sets wrapped, and the block goes to DONE
  - final status_addr = 2**ADDR_WIDTH (4096)
- Circular (mode_circ = 1):
  - ptr wraps to 0 and sets wrapped (sticky); capture continues
  - stop = 1 in CAPTURE goes to DONE; a din_valid on the stop cycle is written first
- DONE: holds until the next arm edge. trig, stop and din_valid are ignored.
- IDLE: trig, stop and din_valid are ignored.
- Arm edge and trig on the same cycle: the arm edge wins and trig is ignored that cycle. Capture begins on a later trig unless force_trig = 1.
- stop outside CAPTURE is ignored.
- status_addr = {wrapped, ptr} at all times.

## Timing
- All outputs are registered.
- Write latency: din_valid/din accepted in cycle N produce bram_we = 1, bram_addr and bram_wr_data in cycle N+1.
- Throughput: one write per clock. Back-to-back din_valid gives consecutive addresses with no bubbles.
- status_done rises in the cycle after the last accepted write cycle, i.e. together with the final bram_we pulse.
- status_busy falls in that same cycle.
- status_busy rises in the cycle after the arm edge.
- Reset values:
  - state IDLE; ptr 0; wrapped 0; mode_circ 0
  - bram_we 0, bram_en_a 0, bram_addr 0, bram_wr_data 0
  - status_busy 0, status_done 0, status_addr 0
  - arm_q resets to 1, so arm held high across reset is not an edge
- Reset mid-capture aborts at the next edge with no further writes. A pending output write from the cycle before reset is suppressed.

## Configuration
- SNAP_CIRC_EN defined: circular mode and the stop input are compiled in as described above.
- SNAP_CIRC_EN undefined:
  - circ and stop are ignored and mode_circ is tied to 0
  - every capture is one-shot and ends after 2**ADDR_WIDTH writes
  - port list is unchanged

## Test plan
- One-shot capture: reset, arm edge, trig after 5 cycles, din_valid continuous with din = index. Required: 4096 writes to addresses 0..4095 with data 0..4095, then status_done = 1 and status_addr = 13'h1000. No writes after that.
- Gapped valid: din_valid at 50% duty. Required: addresses stay contiguous, each write follows its accepted sample by exactly 1 cycle, total of 4096 writes.
- Arm/trig collision: arm edge and trig in the same cycle with force_trig = 0. Required: state ARMED and no write. A trig 3 cycles later starts capture at address 0.
- Circular mode (SNAP_CIRC_EN defined): circ = 1, 5000 valid samples, then stop together with one more valid. Required: last write at address 904, status_addr = {1, 12'd905}, status_done = 1.
- Abort via re-arm: arm edge at sample 100 of a one-shot capture. Required: no writes while ARMED, status_addr = 0, the next capture restarts at address 0.
- Reset mid-capture: rst pulse during CAPTURE. Required: bram_we = 0 from the next edge, all outputs at reset values, arm held high does not re-arm.

Source files
------------

// File: rtl/snapshot_capture_ctrl.sv
// snapshot_capture_ctrl: write-side sequencer for the snapshot capture BRAM (port A).
// Define SNAP_CIRC_EN to compile in circular capture and the stop input.
module snapshot_capture_ctrl #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  arm,
   input  logic                  trig,
   input  logic                  force_trig,
   input  logic                  circ,
   input  logic                  stop,
   input  logic                  din_valid,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  bram_we,
   output logic                  bram_en_a,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [DATA_WIDTH-1:0] bram_wr_data,
   output logic                  status_busy,
   output logic                  status_done,
   output logic [ADDR_WIDTH:0]   status_addr
);
   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
   state_t                r_state, w_next;
   logic                  r_arm_q, r_wrapped, r_mode_circ;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic                  w_arm_edge, w_accept, w_circ, w_stop;
`ifdef SNAP_CIRC_EN
   assign w_circ = circ;
   assign w_stop = stop & r_mode_circ;
`else
   logic w_unused;
   assign w_unused = circ ^ stop;
   assign w_circ   = 1'b0;
   assign w_stop   = 1'b0;
`endif
   assign w_arm_edge  = arm & ~r_arm_q;
   // a sample on the trigger cycle itself is word 0; an arm edge always wins
   assign w_accept    = ~w_arm_edge & din_valid & (r_state == CAPTURE | (r_state == ARMED & trig));
   assign status_addr = {r_wrapped, r_ptr};
   always_comb begin
      w_next = r_state;
      if (w_arm_edge)
         w_next = force_trig ? CAPTURE : ARMED;
      else if (r_state == CAPTURE || (r_state == ARMED && trig))
         w_next = ((w_accept && &r_ptr && !r_mode_circ) || (r_state == CAPTURE && w_stop)) ? DONE : CAPTURE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_arm_q      <= 1'b1;
         r_ptr        <= '0;
         r_wrapped    <= 1'b0;
         r_mode_circ  <= 1'b0;
         bram_we      <= 1'b0;
         bram_en_a    <= 1'b0;
         bram_addr    <= '0;
         bram_wr_data <= '0;
         status_busy  <= 1'b0;
         status_done  <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_arm_q     <= arm;
         bram_we     <= w_accept;
         bram_en_a   <= w_accept;
         status_busy <= (w_next == ARMED) || (w_next == CAPTURE);
         status_done <= w_next == DONE;
         if (w_accept) begin
            bram_addr    <= r_ptr;
            bram_wr_data <= din;
         end
         if (w_arm_edge) begin
            r_ptr       <= '0;
            r_wrapped   <= 1'b0;
            r_mode_circ <= w_circ;
         end else if (w_accept) begin
            r_ptr     <= r_ptr + 1'b1;
            r_wrapped <= r_wrapped | (&r_ptr);
         end
      end
   end
endmodule

// File: tb/tb_snapshot_capture_ctrl.sv
// tb_snapshot_capture_ctrl: directed bench for snapshot_capture_ctrl with a write-stream tracker.
module tb_snapshot_capture_ctrl;
   logic         clk = 1'b0, rst = 1'b1, arm = 1'b1, trig = 1'b0, force_trig = 1'b0;
   logic         circ = 1'b0, stop = 1'b0, din_valid = 1'b0;
   logic [127:0] din = '0;
   logic         bram_we, bram_en_a, status_busy, status_done;
   logic [11:0]  bram_addr;
   logic [127:0] bram_wr_data;
   logic [12:0]  status_addr;
   int           tests = 0, fails = 0, wr_cnt = 0, acc = 0, bad = 0, lat_bad = 0;
   logic [11:0]  exp_addr = '0;
   logic         cap = 1'b0;

   snapshot_capture_ctrl dut (
      .clk(clk), .rst(rst), .arm(arm), .trig(trig), .force_trig(force_trig),
      .circ(circ), .stop(stop), .din_valid(din_valid), .din(din),
      .bram_we(bram_we), .bram_en_a(bram_en_a), .bram_addr(bram_addr),
      .bram_wr_data(bram_wr_data), .status_busy(status_busy),
      .status_done(status_done), .status_addr(status_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // cap = bench belief that the sample driven this cycle is accepted
   task automatic tick();
      logic e;
      e = din_valid && cap;
      @(posedge clk);
      #1;
      if (bram_we !== e || bram_en_a !== bram_we) lat_bad++;
      if (bram_we === 1'b1) begin
         if (bram_addr !== exp_addr || bram_wr_data !== 128'(wr_cnt)) bad++;
         exp_addr++;
         wr_cnt++;
      end
      if (e) begin
         din = din + 1'b1;
         acc++;
      end
   endtask

   task automatic restart();
      exp_addr = '0;
      wr_cnt   = 0;
      acc      = 0;
      din      = '0;
   endtask

   initial begin
      tick();
      tick();
      chk("rst_we", bram_we, 0);
      chk("rst_addr", bram_addr, 0);
      chk("rst_data", bram_wr_data, 0);
      chk("rst_busy", status_busy, 0);
      chk("rst_done", status_done, 0);
      chk("rst_status_addr", status_addr, 0);
      rst = 1'b0;
      tick();
      chk("arm_held_no_edge", status_busy, 0);
      arm = 1'b0;
      tick();
      // one-shot: arm, valid ignored while armed, trig after 5 cycles
      arm = 1'b1;
      tick();
      chk("os_busy_after_arm", status_busy, 1);
      arm = 1'b0;
      din_valid = 1'b1;
      repeat (5) tick();
      restart();
      trig = 1'b1;
      cap = 1'b1;
      tick();
      trig = 1'b0;
      for (int i = 0; i < 4200 && acc < 4096; i++) tick();
      chk("os_final_addr", bram_addr, 12'hfff);
      chk("os_done", status_done, 1);
      chk("os_busy_fall", status_busy, 0);
      chk("os_status_addr", status_addr, 13'h1000);
      cap = 1'b0;
      trig = 1'b1;
      repeat (3) tick();
      chk("os_writes", wr_cnt, 4096);
      chk("os_done_hold", status_done, 1);
      chk("os_stream", bad, 0);
      chk("os_latency", lat_bad, 0);
      // arm edge and trig together: arm wins, no write
      trig = 1'b1;
      arm = 1'b1;
      din_valid = 1'b1;
      tick();
      chk("col_busy", status_busy, 1);
      chk("col_done", status_done, 0);
      chk("col_we", bram_we, 0);
      chk("col_status_addr", status_addr, 0);
      trig = 1'b0;
      tick();
      tick();
      restart();
      trig = 1'b1;
      cap = 1'b1;
      tick();
      chk("col_first_we", bram_we, 1);
      chk("col_first_addr", bram_addr, 0);
      trig = 1'b0;
      for (int i = 0; i < 9000 && acc < 4096; i++) begin
         din_valid = i[0];
         tick();
      end
      chk("gap_done", status_done, 1);
      chk("gap_status_addr", status_addr, 13'h1000);
      cap = 1'b0;
      din_valid = 1'b1;
      tick();
      chk("gap_writes", wr_cnt, 4096);
      chk("gap_stream", bad, 0);
      chk("gap_latency", lat_bad, 0);
      // forced start, then abort by re-arm at sample 100
      arm = 1'b0;
      din_valid = 1'b0;
      tick();
      arm = 1'b1;
      force_trig = 1'b1;
      tick();
      chk("force_busy", status_busy, 1);
      arm = 1'b0;
      force_trig = 1'b0;
      restart();
      cap = 1'b1;
      din_valid = 1'b1;
      repeat (100) tick();
      chk("abort_pre_addr", status_addr, 100);
      arm = 1'b1;
      cap = 1'b0;
      tick();
      chk("abort_status_addr", status_addr, 0);
      chk("abort_busy", status_busy, 1);
      repeat (4) tick();
      chk("abort_writes", wr_cnt, 100);
      restart();
      trig = 1'b1;
      cap = 1'b1;
      tick();
      trig = 1'b0;
      repeat (10) tick();
      chk("rearm_writes", wr_cnt, 11);
      chk("rearm_status_addr", status_addr, 11);
      chk("rearm_stream", bad, 0);
      // reset mid-capture with arm held high
      rst = 1'b1;
      cap = 1'b0;
      tick();
      chk("mid_rst_we", bram_we, 0);
      chk("mid_rst_addr", bram_addr, 0);
      chk("mid_rst_data", bram_wr_data, 0);
      chk("mid_rst_status", {status_busy, status_done, status_addr}, 0);
      rst = 1'b0;
      trig = 1'b1;
      repeat (3) tick();
      chk("post_rst_no_arm", status_busy, 0);
      chk("post_rst_latency", lat_bad, 0);
      trig = 1'b0;
`ifdef SNAP_CIRC_EN
      arm = 1'b0;
      din_valid = 1'b0;
      tick();
      arm = 1'b1;
      circ = 1'b1;
      force_trig = 1'b1;
      tick();
      arm = 1'b0;
      circ = 1'b0;
      force_trig = 1'b0;
      restart();
      cap = 1'b1;
      din_valid = 1'b1;
      repeat (5000) tick();
      chk("circ_wrap_addr", status_addr, {1'b1, 12'd904});
      chk("circ_running", status_done, 0);
      stop = 1'b1;
      tick();
      chk("circ_last_addr", bram_addr, 12'd904);
      chk("circ_status_addr", status_addr, {1'b1, 12'd905});
      chk("circ_done", status_done, 1);
      stop = 1'b0;
      cap = 1'b0;
      tick();
      chk("circ_writes", wr_cnt, 5001);
      chk("circ_stream", bad, 0);
      chk("circ_latency", lat_bad, 0);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
